pres_dc: RTL and testbench
==========================

// Module: pres_dc
// PURPOSE
//   Presettable down-counter and interval timer: the count-down counterpart of the presettable up-counter.
//   Loads a parallel preset P, decrements once per enabled CLOCK edge, and flags terminal count with TC.
//   Used as a programmable delay or divider alongside pres_c in the counter library.
// PARAMETERS
//   reg_size   4   width of preset P and count Q (>=2)
// PORTS
//   CLOCK    in   1          single clock; all state updates on rising edge
//   RESET    in   1          synchronous, active-high reset
//   P        in   reg_size   preset value, sampled when LOAD=1
//   LOAD     in   1          load P into Q (and reload register)
//   ENABLE   in   1          count enable; decrement permitted when 1
//   Q        out  reg_size   current count
//   TC       out  1          terminal-count pulse, 1 cycle wide, registered
//   BUSY     out  1          1 while state==RUN
// BEHAVIOUR
//   - Priority at each rising CLOCK edge: RESET > LOAD > ENABLE > hold.
//   - Reset: Q=0, TC=0, BUSY=0, reload register R=0, state=IDLE. Reset mid-count aborts with no TC.
//   - States:
//       IDLE  after reset
//       RUN   counting
//       DONE  terminal reached
//   - LOAD=1 (any state):
//       Q<=P and R<=P; TC<=0
//       P!=0: state->RUN
//       P==0: state->DONE, no TC
//       LOAD takes effect with 1-cycle latency and overrides a simultaneous decrement or terminal event.
//   - RUN, ENABLE=1, Q>1: Q<=Q-1, TC<=0.
//   - RUN, ENABLE=1, Q==1: Q<=0, TC<=1, state->DONE; BUSY falls on the same edge.
//   - RUN, ENABLE=0: Q holds, TC<=0.
//   - IDLE/DONE: Q holds, ENABLE ignored, TC<=0; only LOAD leaves these states.
//   - TC is high for exactly one cycle: the cycle in which Q first reads 0.
//   - Arithmetic: modulo 2^reg_size, but underflow cannot occur because a decrement from 0 is never issued.
//   - BUSY = (state==RUN), registered with state.
// CONFIGURATION
//   AUTO_RELOAD_EN
//     Defined:
//       - At Q==1 with ENABLE=1: Q<=0, TC<=1, state stays RUN.
//       - Next enabled edge at Q==0: Q<=R, TC<=0.
//       - Period = R+1 enabled cycles, TC once per period.
//       - ENABLE=0 at Q==0: holds 0, TC not repeated.
//       - LOAD with P==0 still goes to DONE.
//     Undefined: one-shot behaviour as above; DONE holds Q=0 until LOAD.
// TESTING (reg_size=4)
//   1. RESET=1 for 2 edges, LOAD=ENABLE=1 held -> Q=0, TC=0, BUSY=0 throughout.
//   2. LOAD=1 with P=3 for 1 edge, then ENABLE=1 -> Q=3,2,1,0; TC=1 only when Q=0; BUSY 1->0 on that edge;
//      Q stays 0 (macro off).
//   3. P=6 loaded, ENABLE=0 for 3 edges at Q=4 -> Q holds 4, TC=0; ENABLE=1 -> 3,2,1,0, one TC.
//   4. At Q=1 with ENABLE=1, assert LOAD with P=5 -> Q=5, TC stays 0, BUSY=1.
//   5. RESET=1 at Q=2 with LOAD=1, P=9 -> next edge Q=0, BUSY=0, TC=0.
//      LOAD with P=0 -> Q=0, DONE, TC never 1.
//   6. AUTO_RELOAD_EN defined, P=2, ENABLE=1 -> Q=2,1,0,2,1,0,2; TC high at each Q=0 (every 3rd edge); BUSY stays 1.

Source files
------------

// File: rtl/pres_dc.sv
`default_nettype none
// ============================================================================
// Module   : pres_dc
// Purpose  : Presettable down-counter / interval timer with one-cycle terminal
//            count pulse. Define AUTO_RELOAD_EN for periodic auto-reload mode.
// Revision : 1.0  initial release
// ============================================================================
module pres_dc #(
  parameter int reg_size = 4
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [reg_size-1:0] P,
  input  logic                LOAD,
  input  logic                ENABLE,
  output logic [reg_size-1:0] Q,
  output logic                TC,
  output logic                BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [reg_size-1:0] ONE  = reg_size'(1);
  localparam logic [reg_size-1:0] ZERO = '0;

  state_t state;

`ifdef AUTO_RELOAD_EN
  logic [reg_size-1:0] reload;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= IDLE;
      Q     <= ZERO;
      TC    <= 1'b0;
      BUSY  <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload <= ZERO;
`endif
    end else if (LOAD) begin
      // A load wins over any decrement or terminal event on the same edge.
      Q  <= P;
      TC <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload <= P;
`endif
      if (P != ZERO) begin
        state <= RUN;
        BUSY  <= 1'b1;
      end else begin
        state <= DONE;
        BUSY  <= 1'b0;
      end
    end else begin
      TC <= 1'b0;
      if (state == RUN && ENABLE) begin
        if (Q > ONE) begin
          Q <= Q - ONE;
        end else if (Q == ONE) begin
          Q  <= ZERO;
          TC <= 1'b1;
`ifndef AUTO_RELOAD_EN
          state <= DONE;
          BUSY  <= 1'b0;
`endif
        end else begin
`ifdef AUTO_RELOAD_EN
          // Zero in RUN only occurs after a terminal event in reload mode.
          Q <= reload;
`endif
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pres_dc.sv
`default_nettype none
// Testbench for pres_dc: directed + random stimulus, queue-based scoreboard
// against a behavioural counter model.
module tb_pres_dc;

  localparam int W = 4;

  logic         CLOCK = 1'b0;
  logic         RESET = 1'b1;
  logic [W-1:0] P = '0;
  logic         LOAD = 1'b0;
  logic         ENABLE = 1'b0;
  logic [W-1:0] Q;
  logic         TC;
  logic         BUSY;

  pres_dc #(.reg_size(W)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .P     (P),
    .LOAD  (LOAD),
    .ENABLE(ENABLE),
    .Q     (Q),
    .TC    (TC),
    .BUSY  (BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   pushed = 0;

  // Reference model: a count, the remembered preset, and whether a countdown
  // is in progress.
  int m_count  = 0;
  int m_preset = 0;
  bit m_active = 0;
  bit m_tc     = 0;

  task automatic model_step(input bit rst, input bit ld, input bit en, input int pv);
    m_tc = 0;
    if (rst) begin
      m_count = 0; m_preset = 0; m_active = 0;
    end else if (ld) begin
      m_count = pv; m_preset = pv; m_active = (pv != 0);
    end else if (m_active && en) begin
      if (m_count == 0) begin
        m_count = m_preset;
      end else begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_tc = 1;
`ifndef AUTO_RELOAD_EN
          m_active = 0;
`endif
        end
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit ld, input bit en, input int pv);
    exp_t e;
    @(negedge CLOCK);
    RESET = rst; LOAD = ld; ENABLE = en; P = W'(pv);
    model_step(rst, ld, en, pv);
    e.q = W'(m_count); e.tc = m_tc; e.busy = m_active;
    exp_q.push_back(e);
    pushed++;
  endtask

  // Monitor: sample just after each rising edge and compare with the oldest
  // expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLOCK);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if ({Q, TC, BUSY} !== e) begin
          bad++;
          $display("FAIL cycle%0d: got Q=%0d TC=%b BUSY=%b, want Q=%0d TC=%b BUSY=%b",
                   total, Q, TC, BUSY, e.q, e.tc, e.busy);
        end
      end
    end
  end

  initial begin
    // Reset held with load/enable active.
    cycle(1, 1, 1, 7);
    cycle(1, 1, 1, 7);
    // One-shot countdown from 3, then linger.
    cycle(0, 1, 0, 3);
    repeat (6) cycle(0, 0, 1, 0);
    // Preset 6, pause at 4, resume.
    cycle(0, 1, 0, 6);
    repeat (2) cycle(0, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 0);
    repeat (5) cycle(0, 0, 1, 0);
    // Load at Q==1 overrides the terminal event.
    cycle(0, 1, 1, 2);
    cycle(0, 0, 1, 0);
    cycle(0, 1, 1, 5);
    repeat (2) cycle(0, 0, 1, 0);
    // Reset beats load mid-count.
    cycle(0, 0, 1, 0);
    cycle(1, 1, 1, 9);
    // Zero preset goes straight to done.
    cycle(0, 1, 1, 0);
    repeat (4) cycle(0, 0, 1, 0);
    // Short preset for the reload sequence.
    cycle(0, 1, 0, 2);
    repeat (7) cycle(0, 0, 1, 0);
    // Maximum preset runs all the way down.
    cycle(0, 1, 0, 15);
    repeat (17) cycle(0, 0, 1, 0);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)));
    end
    @(negedge CLOCK);
    RESET = 0; LOAD = 0; ENABLE = 0;
    repeat (2) @(posedge CLOCK);
    #2;
    total++;
    if (exp_q.size() != 0 || total != pushed + 1) begin
      bad++;
      $display("FAIL drain: pending=%0d checked=%0d issued=%0d", exp_q.size(), total - 1, pushed);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
